trigger_event: RTL
==================

TRIGGER_EVENT -- requirements
Module: trigger_event

Interface
REQ-001 SDW, 32, sample data width in bits.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 cfg_mask  input  SDW  compare mask; 1 = bit participates in match.
REQ-005 cfg_val  input  SDW  compare value.
REQ-006 cfg_clr  input  2  condition select for clear event: 00 none, 01 level match, 10 match rising, 11 match falling.
REQ-007 cfg_inc  input  2  condition select for increment event, same encoding.
REQ-008 cfg_dec  input  2  condition select for decrement event, same encoding.
REQ-009 sti_valid  input  1  input sample valid.
REQ-010 sti_ready  output  1  input sample accepted when high with sti_valid.
REQ-011 sti_data  input  SDW  input sample.
REQ-012 sto_valid  output  1  output sample valid.
REQ-013 sto_ready  input  1  downstream accepts output.
REQ-014 sto_data  output  SDW  registered copy of accepted sample.
REQ-015 sto_tevent  output  2  event code for sto_data: 00 none, 01 clear, 10 increment, 11 decrement.

Function
REQ-016 Input transfer (sti_t) SHALL be sti_valid & sti_ready; output transfer (sto_t) SHALL be sto_valid & sto_ready.
REQ-017 sti_ready SHALL equal ~sto_valid | sto_ready (combinational, single register stage, no bubble under continuous flow).
REQ-018 match SHALL be 1 when ((sti_data ^ cfg_val) & cfg_mask) == 0; cfg_mask = 0 makes every sample match.
REQ-019 rise SHALL be match & ~prv_match & prv_vld; fall SHALL be ~match & prv_match & prv_vld.
REQ-020 prv_match and prv_vld SHALL update only on sti_t (prv_match <= match, prv_vld <= 1); the first sample after reset SHALL never produce rise or fall.
REQ-021 Each of clr/inc/dec SHALL be true when its selected condition is true; select 00 is never true.
REQ-022 Event priority SHALL be clr > inc > dec; sto_tevent SHALL encode the highest true event, 00 if none.
REQ-023 On sti_t, sto_data and sto_tevent SHALL load in the same cycle and sto_valid SHALL be 1 from the next cycle (latency 1).
REQ-024 On sto_t without sti_t, sto_valid SHALL clear next cycle; on simultaneous sto_t and sti_t, sto_valid SHALL stay 1 with new data.
REQ-025 While sto_valid & ~sto_ready, sto_data and sto_tevent SHALL hold stable; match history SHALL not advance.
REQ-026 Configuration inputs SHALL be sampled combinationally at sti_t; changing them mid-stream affects only subsequent samples and does not clear prv_vld.

Reset
REQ-027 On rst = 0, sto_valid, sto_tevent, sto_data, prv_match, prv_vld SHALL be 0 immediately, asynchronously.
REQ-028 Reset release SHALL be synchronous to clk; the first sti_t may occur in the first cycle after release.
REQ-029 Reset mid-transfer SHALL discard the held output sample and match history.

Configuration
REQ-030 Macro TRIGGER_EVENT_EDGE_EN defined: rise/fall detection and prv_match/prv_vld registers implemented per REQ-019/020.
REQ-031 Macro TRIGGER_EVENT_EDGE_EN undefined: prv_match/prv_vld omitted, selects 10 and 11 SHALL behave as 00 (never true); level match unaffected.

Verification
REQ-032 Reset, cfg_mask=0xFF, cfg_val=0x5A, cfg_inc=01, sto_ready=1, stream 0x5A,0x00,0x15A -> sto_tevent 10,00,10 each one cycle after its input.
REQ-033 With EDGE_EN, cfg_clr=10, cfg_dec=11, cfg_val=0x1, mask=0x1, stream 1,1,0,1 after reset -> tevent 00,00,11,01 (first sample no edge).
REQ-034 cfg_clr=01, cfg_inc=01, cfg_dec=01, matching sample -> tevent 01 (priority).
REQ-035 sto_ready=0 for 3 cycles after first output with sti_valid=1 -> sti_ready=0, sto_data/tevent stable, next sample's edge computed against first sample only.
REQ-036 rst asserted while sto_valid=1 -> sto_valid=0 same cycle; after release first sample with cfg_inc=10 and match=1 -> tevent 00.
REQ-037 Without EDGE_EN, cfg_inc=10, stream 0,1 toggling match -> tevent always 00.

Source files
------------

// File: rtl/trigger_event.sv
// Sample-stream trigger: compares each sample against a masked value and tags it with a clear/inc/dec event.
// Define TRIGGER_EVENT_EDGE_EN to add match rising/falling-edge conditions.
module trigger_event #(
  parameter int SDW = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [SDW-1:0] cfg_mask,
  input  logic [SDW-1:0] cfg_val,
  input  logic [1:0]     cfg_clr,
  input  logic [1:0]     cfg_inc,
  input  logic [1:0]     cfg_dec,
  input  logic           sti_valid,
  output logic           sti_ready,
  input  logic [SDW-1:0] sti_data,
  output logic           sto_valid,
  input  logic           sto_ready,
  output logic [SDW-1:0] sto_data,
  output logic [1:0]     sto_tevent
);

  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_LEVEL = 2'b01;
  localparam logic [1:0] SEL_RISE  = 2'b10;

  localparam logic [1:0] EV_NONE = 2'b00;
  localparam logic [1:0] EV_CLR  = 2'b01;
  localparam logic [1:0] EV_INC  = 2'b10;
  localparam logic [1:0] EV_DEC  = 2'b11;

  function automatic logic sel_hit(input logic [1:0] sel, input logic lvl,
                                   input logic rise, input logic fall);
    case (sel)
      SEL_NONE:  sel_hit = 1'b0;
      SEL_LEVEL: sel_hit = lvl;
      SEL_RISE:  sel_hit = rise;
      default:   sel_hit = fall;
    endcase
  endfunction

  function automatic logic [1:0] prio_encode(input logic clr, input logic inc,
                                             input logic dec);
    if (clr)      prio_encode = EV_CLR;
    else if (inc) prio_encode = EV_INC;
    else if (dec) prio_encode = EV_DEC;
    else          prio_encode = EV_NONE;
  endfunction

  logic       sti_t;
  logic       match_p0;
  logic       rise_p0;
  logic       fall_p0;
  logic [1:0] tevent_p0;

  assign sti_ready = ~sto_valid | sto_ready;
  assign sti_t     = sti_valid & sti_ready;
  assign match_p0  = ((sti_data ^ cfg_val) & cfg_mask) == '0;

`ifdef TRIGGER_EVENT_EDGE_EN
  logic prv_match;
  logic prv_vld;

  assign rise_p0 = match_p0 & ~prv_match & prv_vld;
  assign fall_p0 = ~match_p0 & prv_match & prv_vld;

  // Match history advances only on accepted samples, so stalls never corrupt edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prv_match <= 1'b0;
      prv_vld   <= 1'b0;
    end else if (sti_t) begin
      prv_match <= match_p0;
      prv_vld   <= 1'b1;
    end
  end
`else
  assign rise_p0 = 1'b0;
  assign fall_p0 = 1'b0;
`endif

  assign tevent_p0 = prio_encode(sel_hit(cfg_clr, match_p0, rise_p0, fall_p0),
                                 sel_hit(cfg_inc, match_p0, rise_p0, fall_p0),
                                 sel_hit(cfg_dec, match_p0, rise_p0, fall_p0));

  // Output register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sto_valid  <= 1'b0;
      sto_data   <= '0;
      sto_tevent <= EV_NONE;
    end else begin
      if (sti_t) begin
        sto_data   <= sti_data;
        sto_tevent <= tevent_p0;
        sto_valid  <= 1'b1;
      end else if (sto_ready) begin
        sto_valid  <= 1'b0;
      end
    end
  end

endmodule
